spi_reg_arbiter: RTL and testbench

- Shares one single-port register bank between two requesters: the SPI side (synchronized single-cycle read/write pulses from the SPI slave) and an internal fabric requester (req/ack handshake).
- Buffers one SPI access so that no SPI pulse is lost while the bank is busy.
- Arbitrates round-robin, sequences the bank's one-cycle read latency, and returns read data to the winning side.
- Sits between the SPI slave/pulse synchronizers and the register bank in the clk_32m domain.

---
 rtl/spi_reg_arbiter.sv | 167 ++++++++++++++++
 tb/tb_spi_reg_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_arbiter.sv
// Round-robin arbiter sharing one single-port register bank between a buffered
// SPI pulse interface and an internal req/ack requester (clk_32m domain).
module spi_reg_arbiter #(
    parameter int unsigned AW = 7,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          spi_re_p,
    input  logic          spi_we_p,
    input  logic [AW-1:0] spi_addr,
    input  logic [DW-1:0] spi_wdat,
    output logic [DW-1:0] spi_rdat,
    output logic          spi_rvalid,

    input  logic          int_req,
    input  logic          int_we,
    input  logic [AW-1:0] int_addr,
    input  logic [DW-1:0] int_wdat,
    output logic          int_ack,
    output logic [DW-1:0] int_rdat,

    output logic          bank_en,
    output logic          bank_we,
    output logic [AW-1:0] bank_addr,
    output logic [DW-1:0] bank_wdat,
    input  logic [DW-1:0] bank_rdat,

    input  logic          err_clr,
    output logic          spi_overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;

    logic            slot_valid;
    logic            slot_we;
    logic [AW-1:0]   slot_addr;
    logic [DW-1:0]   slot_wdat;

    logic            last_grant_spi;
    logic            cur_spi;

    logic            spi_pulse;
    logic            int_cand;
    logic            grant_spi;
    logic            grant_int;
    logic            set_overrun;

    // Arbitration: int_req is masked during its own ack cycle so a requester
    // that drops req after seeing ack is not granted a second time.
    always_comb begin
        spi_pulse   = spi_re_p | spi_we_p;
        int_cand    = int_req & ~int_ack;
        grant_spi   = 1'b0;
        grant_int   = 1'b0;
        if (state == IDLE) begin
            if (slot_valid && int_cand) begin
                grant_spi = ~last_grant_spi;
                grant_int = last_grant_spi;
            end else begin
                grant_spi = slot_valid;
                grant_int = int_cand;
            end
        end
        set_overrun = (spi_re_p & spi_we_p) |
                      (spi_pulse & slot_valid & ~grant_spi);
    end

    // One-deep SPI slot; it frees on the grant edge so a pulse there still loads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_valid  <= 1'b0;
            slot_we     <= 1'b0;
            slot_addr   <= '0;
            slot_wdat   <= '0;
            spi_overrun <= 1'b0;
        end else begin
            if (spi_pulse) begin
                if (!slot_valid || grant_spi) begin
                    slot_valid <= 1'b1;
                    slot_we    <= spi_we_p;
                    slot_addr  <= spi_addr;
                    slot_wdat  <= spi_wdat;
                end
            end else if (grant_spi) begin
                slot_valid <= 1'b0;
            end

            if (set_overrun) begin
                spi_overrun <= 1'b1;
            end else if (err_clr) begin
                spi_overrun <= 1'b0;
            end
        end
    end

    // Access sequencer: grant, one-cycle bank strobe, then return data / ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            last_grant_spi <= 1'b0;
            cur_spi        <= 1'b0;
            bank_en        <= 1'b0;
            bank_we        <= 1'b0;
            bank_addr      <= '0;
            bank_wdat      <= '0;
            spi_rdat       <= '0;
            spi_rvalid     <= 1'b0;
            int_ack        <= 1'b0;
            int_rdat       <= '0;
        end else begin
            spi_rvalid <= 1'b0;
            int_ack    <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_spi) begin
                        bank_en        <= 1'b1;
                        bank_we        <= slot_we;
                        bank_addr      <= slot_addr;
                        bank_wdat      <= slot_wdat;
                        cur_spi        <= 1'b1;
                        last_grant_spi <= 1'b1;
                        state          <= ISSUE;
                    end else if (grant_int) begin
                        bank_en        <= 1'b1;
                        bank_we        <= int_we;
                        bank_addr      <= int_addr;
                        bank_wdat      <= int_wdat;
                        cur_spi        <= 1'b0;
                        last_grant_spi <= 1'b0;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    bank_en <= 1'b0;
                    state   <= DONE;
                end
                DONE: begin
                    if (!bank_we) begin
                        if (cur_spi) begin
                            spi_rdat   <= bank_rdat;
                            spi_rvalid <= 1'b1;
                        end else begin
                            int_rdat <= bank_rdat;
                        end
                    end
                    if (!cur_spi) begin
                        int_ack <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    bank_en <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Directed bench for spi_reg_arbiter; the bank model returns addr ^ 0xD5 on reads.
module tb_spi_reg_arbiter;

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          spi_re_p, spi_we_p;
    logic [AW-1:0] spi_addr;
    logic [DW-1:0] spi_wdat;
    logic [DW-1:0] spi_rdat;
    logic          spi_rvalid;
    logic          int_req, int_we;
    logic [AW-1:0] int_addr;
    logic [DW-1:0] int_wdat;
    logic          int_ack;
    logic [DW-1:0] int_rdat;
    logic          bank_en, bank_we;
    logic [AW-1:0] bank_addr;
    logic [DW-1:0] bank_wdat;
    logic [DW-1:0] bank_rdat = '0;
    logic          err_clr;
    logic          spi_overrun;

    int vectors    = 0;
    int miscompares = 0;
    int n0;

    logic [15:0] acc_q [$];

    always #5 clk = ~clk;

    spi_reg_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .spi_re_p(spi_re_p), .spi_we_p(spi_we_p), .spi_addr(spi_addr), .spi_wdat(spi_wdat),
        .spi_rdat(spi_rdat), .spi_rvalid(spi_rvalid),
        .int_req(int_req), .int_we(int_we), .int_addr(int_addr), .int_wdat(int_wdat),
        .int_ack(int_ack), .int_rdat(int_rdat),
        .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr), .bank_wdat(bank_wdat),
        .bank_rdat(bank_rdat),
        .err_clr(err_clr), .spi_overrun(spi_overrun)
    );

    // Bank model with one-cycle read latency, plus a log of every bank access.
    always @(posedge clk) begin
        if (reset && bank_en) begin
            if (!bank_we) bank_rdat <= 8'({1'b0, bank_addr}) ^ 8'hD5;
            acc_q.push_back({bank_we, bank_addr, bank_wdat});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        spi_re_p = 1'b0;
        spi_we_p = 1'b0;
        int_req  = 1'b0;
        err_clr  = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        spi_addr = '0; spi_wdat = '0;
        int_we = 1'b0; int_addr = '0; int_wdat = '0;
        do_reset();

        check("rst_bank_en",  32'(bank_en), 32'd0);
        check("rst_rvalid",   32'(spi_rvalid), 32'd0);
        check("rst_int_ack",  32'(int_ack), 32'd0);
        check("rst_overrun",  32'(spi_overrun), 32'd0);
        check("rst_spi_rdat", 32'(spi_rdat), 32'd0);

        // Single SPI read of 0x7D
        n0 = acc_q.size();
        spi_re_p = 1'b1; spi_addr = 7'h7D; step();
        spi_re_p = 1'b0;
        check("t1_en_k", 32'(bank_en), 32'd0);
        step();
        check("t1_en",   32'(bank_en), 32'd1);
        check("t1_we",   32'(bank_we), 32'd0);
        check("t1_addr", 32'(bank_addr), 32'h7D);
        step();
        check("t1_en_off", 32'(bank_en), 32'd0);
        check("t1_rv_early", 32'(spi_rvalid), 32'd0);
        step();
        check("t1_rvalid", 32'(spi_rvalid), 32'd1);
        check("t1_rdat",   32'(spi_rdat), 32'hA8);
        step();
        check("t1_rvalid_off", 32'(spi_rvalid), 32'd0);
        check("t1_rdat_hold",  32'(spi_rdat), 32'hA8);
        check("t1_accesses",   32'(acc_q.size() - n0), 32'd1);

        // Internal write 0x55 to 0x10, req held through the ack cycle
        n0 = acc_q.size();
        int_req = 1'b1; int_we = 1'b1; int_addr = 7'h10; int_wdat = 8'h55; step();
        check("t2_en",   32'(bank_en), 32'd1);
        check("t2_we",   32'(bank_we), 32'd1);
        check("t2_addr", 32'(bank_addr), 32'h10);
        check("t2_wdat", 32'(bank_wdat), 32'h55);
        step();
        check("t2_ack_early", 32'(int_ack), 32'd0);
        step();
        check("t2_ack", 32'(int_ack), 32'd1);
        step();
        check("t2_ack_off", 32'(int_ack), 32'd0);
        check("t2_no_regrant", 32'(bank_en), 32'd0);
        int_req = 1'b0;
        step(); step(); step();
        check("t2_accesses", 32'(acc_q.size() - n0), 32'd1);
        check("t2_int_rdat", 32'(int_rdat), 32'd0);
        check("t2_addr_hold", 32'(bank_addr), 32'h10);

        // Round robin after reset: SPI first, then alternating
        do_reset();
        n0 = acc_q.size();
        int_wdat = 8'h00;
        spi_re_p = 1'b1; spi_addr = 7'h20; step();
        spi_re_p = 1'b0; int_req = 1'b1; int_we = 1'b0; int_addr = 7'h40; step();
        spi_re_p = 1'b1; spi_addr = 7'h21; step();
        spi_re_p = 1'b0; step(); step(); step(); step();
        spi_re_p = 1'b1; spi_addr = 7'h22; step();
        spi_re_p = 1'b0; step(); step(); step(); step(); step();
        check("t3_int_ack", 32'(int_ack), 32'd1);
        int_req = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("t3_accesses", 32'(acc_q.size() - n0), 32'd5);
        if (acc_q.size() - n0 == 5) begin
            check("t3_g0", 32'(acc_q[n0][14:8]),   32'h20);
            check("t3_g1", 32'(acc_q[n0+1][14:8]), 32'h40);
            check("t3_g2", 32'(acc_q[n0+2][14:8]), 32'h21);
            check("t3_g3", 32'(acc_q[n0+3][14:8]), 32'h40);
            check("t3_g4", 32'(acc_q[n0+4][14:8]), 32'h22);
        end
        check("t3_overrun", 32'(spi_overrun), 32'd0);
        check("t3_int_rdat", 32'(int_rdat), 32'h95);

        // SPI pulses every two cycles during an internal read
        do_reset();
        n0 = acc_q.size();
        int_req = 1'b1; int_we = 1'b0; int_addr = 7'h30;
        spi_re_p = 1'b1; spi_addr = 7'h31; step();
        spi_re_p = 1'b0; step();
        spi_re_p = 1'b1; spi_addr = 7'h32; step();
        spi_re_p = 1'b0;
        check("t4_overrun", 32'(spi_overrun), 32'd1);
        check("t4_int_ack", 32'(int_ack), 32'd1);
        check("t4_int_rdat", 32'(int_rdat), 32'hE5);
        int_req = 1'b0; step();
        spi_re_p = 1'b1; spi_addr = 7'h33; step();
        spi_re_p = 1'b0;
        check("t4_two_accesses", 32'(acc_q.size() - n0), 32'd2);
        step();
        check("t4_rvalid", 32'(spi_rvalid), 32'd1);
        check("t4_rdat",   32'(spi_rdat), 32'hE4);
        for (int i = 0; i < 5; i++) step();
        check("t4_accesses", 32'(acc_q.size() - n0), 32'd3);
        if (acc_q.size() - n0 == 3) begin
            check("t4_g0", 32'(acc_q[n0][14:8]),   32'h30);
            check("t4_g1", 32'(acc_q[n0+1][14:8]), 32'h31);
            check("t4_g2", 32'(acc_q[n0+2][14:8]), 32'h33);
        end
        check("t4_overrun_sticky", 32'(spi_overrun), 32'd1);
        err_clr = 1'b1; step();
        err_clr = 1'b0;
        check("t4_overrun_clr", 32'(spi_overrun), 32'd0);

        // Read and write pulses together, err_clr in the same cycle
        n0 = acc_q.size();
        spi_re_p = 1'b1; spi_we_p = 1'b1; spi_addr = 7'h05; spi_wdat = 8'h3C; err_clr = 1'b1; step();
        spi_re_p = 1'b0; spi_we_p = 1'b0; err_clr = 1'b0;
        check("t5_overrun", 32'(spi_overrun), 32'd1);
        step(); step(); step();
        check("t5_no_rvalid", 32'(spi_rvalid), 32'd0);
        check("t5_no_ack",    32'(int_ack), 32'd0);
        check("t5_accesses",  32'(acc_q.size() - n0), 32'd1);
        if (acc_q.size() - n0 == 1)
            check("t5_write", 32'(acc_q[n0]), 32'({1'b1, 7'h05, 8'h3C}));
        check("t5_rdat_hold", 32'(spi_rdat), 32'hE6);

        // Reset during ISSUE, then a clean read
        spi_re_p = 1'b1; spi_addr = 7'h7D; step();
        spi_re_p = 1'b0; step();
        check("t6_issue_en", 32'(bank_en), 32'd1);
        reset = 1'b0;
        #1;
        check("t6_rst_en",      32'(bank_en), 32'd0);
        check("t6_rst_rvalid",  32'(spi_rvalid), 32'd0);
        check("t6_rst_ack",     32'(int_ack), 32'd0);
        check("t6_rst_overrun", 32'(spi_overrun), 32'd0);
        check("t6_rst_rdat",    32'(spi_rdat), 32'd0);
        step();
        reset = 1'b1;
        n0 = acc_q.size();
        spi_re_p = 1'b1; spi_addr = 7'h11; step();
        spi_re_p = 1'b0;
        check("t6_en_k", 32'(bank_en), 32'd0);
        step();
        check("t6_en",   32'(bank_en), 32'd1);
        check("t6_addr", 32'(bank_addr), 32'h11);
        step();
        check("t6_en_off", 32'(bank_en), 32'd0);
        step();
        check("t6_rvalid", 32'(spi_rvalid), 32'd1);
        check("t6_rdat",   32'(spi_rdat), 32'hC4);
        step();
        check("t6_rvalid_off", 32'(spi_rvalid), 32'd0);
        check("t6_accesses", 32'(acc_q.size() - n0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
